ofm_write_receiver: RTL and testbench

- Receiving end of the accelerator's OFM write port: captures each beat of {write_out_ofm_en, ofm_addr_b, write_ofm_size, ofm_data_out}.
- Buffers beats in a small FIFO, then serialises each beat into per-element memory writes over a valid/ready interface.
- Sits between the accelerator top level and the external OFM memory or memory-controller port.
- The OFM port has no backpressure, so the block absorbs bursts and flags overflow.

---
 rtl/ofm_rx_pkg.sv | 32 +++
 rtl/ofm_beat_fifo.sv | 57 +++++
 rtl/ofm_write_receiver.sv | 159 +++++++++++++++
 tb/tb_ofm_write_receiver.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofm_rx_pkg.sv
// Shared types and constants for the OFM write receiver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, default widths, lane count, address-width helper, beat record.
package ofm_rx_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_INOUT_WIDTH  = 256;
    localparam int DEF_OFM_RAM_SIZE = 692224;
    localparam int LANES            = DEF_INOUT_WIDTH / DEF_DATA_WIDTH;
    localparam int SIZE_W           = 5;

    function automatic int addr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    localparam int ADDR_W = addr_width(DEF_OFM_RAM_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    // One captured OFM beat; size is already clamped to LANES.
    typedef struct packed {
        logic [ADDR_W-1:0]          addr;
        logic [SIZE_W-1:0]          size;
        logic [DEF_INOUT_WIDTH-1:0] data;
    } beat_t;

endpackage

// File: rtl/ofm_beat_fifo.sv
// Synchronous beat FIFO (first-word fall-through read data).
// Latency: a pushed entry is visible on pop_dat the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
// Ports: push/push_dat write side, pop/pop_dat read side, full/empty/count status.
module ofm_beat_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ofm_write_receiver.sv
// OFM write-port receiver: buffers beats, serialises them into per-element memory writes.
// Latency: beat sampled at edge N drives mem_wr_valid after edge N+2; a size-S beat takes S+1 cycles.
// Backpressure: mem_wr_ready stalls the element stream; the OFM port cannot stall, so a full FIFO drops the beat and sets overflow.
// Ports: OFM beat inputs (write_out_ofm_en, ofm_addr_b, write_ofm_size, ofm_data_out),
//        element write valid/ready (mem_wr_*), status (idle, overflow, beat_count).
// Optional: OFM_ADDR_RANGE_CHECK_EN adds a sticky range_err output and suppresses writes at or above OFM_RAM_SIZE.
// Widths of the beat record come from ofm_rx_pkg, so parameter overrides must match the package defaults.
module ofm_write_receiver
    import ofm_rx_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int INOUT_WIDTH  = DEF_INOUT_WIDTH,
    parameter int OFM_RAM_SIZE = DEF_OFM_RAM_SIZE,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                write_out_ofm_en,
    input  logic [addr_width(OFM_RAM_SIZE)-1:0] ofm_addr_b,
    input  logic [4:0]                          write_ofm_size,
    input  logic [INOUT_WIDTH-1:0]              ofm_data_out,
    output logic                                mem_wr_valid,
    input  logic                                mem_wr_ready,
    output logic [addr_width(OFM_RAM_SIZE)-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0]               mem_wr_data,
    output logic                                idle,
    output logic                                overflow,
    output logic [15:0]                         beat_count
`ifdef OFM_ADDR_RANGE_CHECK_EN
    ,
    output logic                                range_err
`endif
);

    localparam int AW     = addr_width(OFM_RAM_SIZE);
    localparam int LANE_W = $clog2(LANES);

    state_t                      state;
    beat_t                       in_beat;
    beat_t                       head_beat;
    beat_t                       cur_beat;
    logic                        push_req;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [SIZE_W-1:0]           lane;
    logic [SIZE_W-1:0]           lane_nxt;
    logic [AW-1:0]               next_addr;
    logic [DATA_WIDTH-1:0]       next_data;
    logic                        advance;
    logic                        head_ok;
    logic                        next_ok;

    assign in_beat.addr = ofm_addr_b;
    assign in_beat.size = (write_ofm_size > SIZE_W'(LANES)) ? SIZE_W'(LANES) : write_ofm_size;
    assign in_beat.data = ofm_data_out;

    assign push_req  = write_out_ofm_en && (write_ofm_size != '0);
    assign fifo_pop  = (state == LOAD);
    assign fifo_push = push_req && (!fifo_full || fifo_pop);

    ofm_beat_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (in_beat),
        .pop      (fifo_pop),
        .pop_dat  (head_beat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign lane_nxt  = lane + 1'b1;
    assign next_addr = cur_beat.addr + AW'(lane_nxt);
    assign next_data = cur_beat.data[32'(lane_nxt[LANE_W-1:0])*DATA_WIDTH +: DATA_WIDTH];
    // A suppressed (out-of-range) element has valid low and is consumed unconditionally.
    assign advance   = mem_wr_ready || !mem_wr_valid;

`ifdef OFM_ADDR_RANGE_CHECK_EN
    assign head_ok = (32'(head_beat.addr) < 32'(OFM_RAM_SIZE));
    assign next_ok = (32'(next_addr) < 32'(OFM_RAM_SIZE));
`else
    assign head_ok = 1'b1;
    assign next_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cur_beat     <= '0;
            lane         <= '0;
            mem_wr_valid <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= '0;
            idle         <= 1'b1;
            overflow     <= 1'b0;
            beat_count   <= '0;
`ifdef OFM_ADDR_RANGE_CHECK_EN
            range_err    <= 1'b0;
`endif
        end else begin
            if (fifo_push)             beat_count <= beat_count + 16'd1;
            if (push_req && !fifo_push) overflow  <= 1'b1;

            case (state)
                IDLE: begin
                    if (fifo_count != '0) begin
                        state <= LOAD;
                        idle  <= 1'b0;
                    end else begin
                        idle  <= !fifo_push;
                    end
                end
                LOAD: begin
                    cur_beat     <= head_beat;
                    lane         <= '0;
                    mem_wr_addr  <= head_beat.addr;
                    mem_wr_data  <= head_beat.data[DATA_WIDTH-1:0];
                    mem_wr_valid <= head_ok;
`ifdef OFM_ADDR_RANGE_CHECK_EN
                    if (!head_ok) range_err <= 1'b1;
`endif
                    idle         <= 1'b0;
                    state        <= SEND;
                end
                SEND: begin
                    if (advance) begin
                        if (lane_nxt == cur_beat.size) begin
                            mem_wr_valid <= 1'b0;
                            if (!fifo_empty) begin
                                state <= LOAD;
                                idle  <= 1'b0;
                            end else begin
                                state <= IDLE;
                                idle  <= !fifo_push;
                            end
                        end else begin
                            lane         <= lane_nxt;
                            mem_wr_addr  <= next_addr;
                            mem_wr_data  <= next_data;
                            mem_wr_valid <= next_ok;
`ifdef OFM_ADDR_RANGE_CHECK_EN
                            if (!next_ok) range_err <= 1'b1;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ofm_write_receiver.sv
// Self-checking bench for ofm_write_receiver: vector table plus hand-written corner sequences,
// expected elements queued at drive time and compared as the DUT issues writes.
module tb_ofm_write_receiver;
    import ofm_rx_pkg::*;

    localparam int DW  = 16;
    localparam int IW  = 256;
    localparam int RAM = 692224;
    localparam int FD  = 8;
    localparam int AW  = addr_width(RAM);

    logic          clk;
    logic          rst;
    logic          write_out_ofm_en;
    logic [AW-1:0] ofm_addr_b;
    logic [4:0]    write_ofm_size;
    logic [IW-1:0] ofm_data_out;
    logic          mem_wr_valid;
    logic          mem_wr_ready;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          idle;
    logic          overflow;
    logic [15:0]   beat_count;
`ifdef OFM_ADDR_RANGE_CHECK_EN
    logic          range_err;
`endif

    ofm_write_receiver #(
        .DATA_WIDTH   (DW),
        .INOUT_WIDTH  (IW),
        .OFM_RAM_SIZE (RAM),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .write_out_ofm_en (write_out_ofm_en),
        .ofm_addr_b       (ofm_addr_b),
        .write_ofm_size   (write_ofm_size),
        .ofm_data_out     (ofm_data_out),
        .mem_wr_valid     (mem_wr_valid),
        .mem_wr_ready     (mem_wr_ready),
        .mem_wr_addr      (mem_wr_addr),
        .mem_wr_data      (mem_wr_data),
        .idle             (idle),
        .overflow         (overflow),
        .beat_count       (beat_count)
`ifdef OFM_ADDR_RANGE_CHECK_EN
        ,
        .range_err        (range_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } elem_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [4:0]    size;
        logic [DW-1:0] base;
        int            exp_writes;
        int            exp_bc_inc;
    } vec_t;

    elem_t exp_q[$];
    vec_t  vecs[6];
    int    checks      = 0;
    int    errors      = 0;
    int    writes_seen = 0;
    int    bc_model    = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_beat(input logic [AW-1:0] addr, input logic [4:0] size,
                            input logic [DW-1:0] base, input bit exp_acc);
        int n;
        write_out_ofm_en = 1'b1;
        ofm_addr_b       = addr;
        write_ofm_size   = size;
        for (int i = 0; i < 16; i++) ofm_data_out[i*DW +: DW] = base + DW'(i);
        if (exp_acc && size != 0) begin
            bc_model++;
            n = (size > 16) ? 16 : int'(size);
            for (int i = 0; i < n; i++) begin
                elem_t e;
                e.addr = addr + AW'(i);
                e.data = base + DW'(i);
`ifdef OFM_ADDR_RANGE_CHECK_EN
                if (32'(e.addr) < RAM) exp_q.push_back(e);
`else
                exp_q.push_back(e);
`endif
            end
        end
        tick();
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (idle !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        chk("idle_timeout", (n >= max_cycles), 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // Scoreboard / handshake monitor.
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", mem_wr_valid, 1);
                chk("hold_addr", mem_wr_addr, prev_addr);
                chk("hold_data", mem_wr_data, prev_data);
            end
            if (mem_wr_valid && mem_wr_ready) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %0h, expected no write", mem_wr_addr, mem_wr_data);
                end else begin
                    elem_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", mem_wr_addr, e.addr);
                    chk("wr_data", mem_wr_data, e.data);
                end
            end
            prev_stall = mem_wr_valid && !mem_wr_ready;
            prev_addr  = mem_wr_addr;
            prev_data  = mem_wr_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat[4];
        int w0;
        int bc0;

        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        vecs[0] = '{addr: 200,  size: 5,  base: 16'h1000, exp_writes: 5,  exp_bc_inc: 1};
        vecs[1] = '{addr: 300,  size: 0,  base: 16'h2000, exp_writes: 0,  exp_bc_inc: 0};
        vecs[2] = '{addr: 400,  size: 20, base: 16'h3000, exp_writes: 16, exp_bc_inc: 1};
        vecs[3] = '{addr: 1000, size: 1,  base: 16'hABCD, exp_writes: 1,  exp_bc_inc: 1};
        vecs[4] = '{addr: 50,   size: 31, base: 16'h0100, exp_writes: 16, exp_bc_inc: 1};
        vecs[5] = '{addr: 600,  size: 16, base: 16'hFF00, exp_writes: 16, exp_bc_inc: 1};

        rst              = 1'b1;
        write_out_ofm_en = 1'b0;
        ofm_addr_b       = '0;
        write_ofm_size   = '0;
        ofm_data_out     = '0;
        mem_wr_ready     = 1'b1;
        repeat (3) tick();

        chk("rst_valid", mem_wr_valid, 0);
        chk("rst_addr", mem_wr_addr, 0);
        chk("rst_data", mem_wr_data, 0);
        chk("rst_idle", idle, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_beat_count", beat_count, 0);
`ifdef OFM_ADDR_RANGE_CHECK_EN
        chk("rst_range_err", range_err, 0);
`endif
        rst = 1'b0;
        tick();

        // Single full beat: latency and 16 sequential writes.
        w0 = writes_seen;
        put_beat(100, 16, 16'h0000, 1);
        write_out_ofm_en = 1'b0;
        chk("lat_valid_n", mem_wr_valid, 0);
        chk("lat_idle_n", idle, 0);
        tick();
        chk("lat_valid_n1", mem_wr_valid, 0);
        tick();
        chk("lat_valid_n2", mem_wr_valid, 1);
        chk("lat_addr_n2", mem_wr_addr, 100);
        wait_idle(100);
        chk("beat1_writes", writes_seen - w0, 16);
        chk("beat1_count", beat_count, bc_model);
        chk("beat1_idle", idle, 1);

        // Vector table.
        for (int v = 0; v < 6; v++) begin
            w0  = writes_seen;
            bc0 = bc_model;
            put_beat(vecs[v].addr, vecs[v].size, vecs[v].base, 1);
            write_out_ofm_en = 1'b0;
            wait_idle(100);
            chk("vec_writes", writes_seen - w0, vecs[v].exp_writes);
            chk("vec_bc_inc", bc_model - bc0, vecs[v].exp_bc_inc);
            chk("vec_beat_count", beat_count, bc_model & 16'hFFFF);
        end

        // Ready toggling 1,0,0,1 during SEND.
        w0 = writes_seen;
        put_beat(500, 8, 16'h6000, 1);
        write_out_ofm_en = 1'b0;
        for (int k = 0; k < 100 && idle !== 1'b1; k++) begin
            mem_wr_ready = pat[k % 4];
            tick();
        end
        mem_wr_ready = 1'b1;
        wait_idle(100);
        chk("toggle_writes", writes_seen - w0, 8);

        // Overflow: one beat parked in the holding register, then 10 strobes into an 8-deep FIFO.
        chk("pre_overflow", overflow, 0);
        mem_wr_ready = 1'b0;
        w0 = writes_seen;
        put_beat(800, 2, 16'h9000, 1);
        write_out_ofm_en = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin
            put_beat(AW'(900 + 16*i), 2, DW'(16'hA000 + 16*i), (i < FD));
        end
        write_out_ofm_en = 1'b0;
        chk("overflow_set", overflow, 1);
        chk("overflow_beat_count", beat_count, bc_model & 16'hFFFF);
        chk("overflow_no_write", writes_seen - w0, 0);
        mem_wr_ready = 1'b1;
        wait_idle(300);
        chk("overflow_drain_writes", writes_seen - w0, 18);
        chk("overflow_sticky", overflow, 1);

        // Reset in the middle of SEND at lane 7.
        put_beat(2000, 16, 16'h7000, 1);
        write_out_ofm_en = 1'b0;
        begin
            int n = 0;
            while (!(mem_wr_valid === 1'b1 && mem_wr_addr === AW'(2007)) && n < 30) begin
                tick();
                n++;
            end
            chk("reach_lane7_timeout", (n >= 30), 0);
        end
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        bc_model = 0;
        chk("midrst_valid", mem_wr_valid, 0);
        chk("midrst_idle", idle, 1);
        chk("midrst_beat_count", beat_count, 0);
        chk("midrst_overflow", overflow, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_valid", mem_wr_valid, 0);
        chk("post_rst_idle", idle, 1);

`ifdef OFM_ADDR_RANGE_CHECK_EN
        // Beat straddling the end of OFM memory.
        w0 = writes_seen;
        put_beat(AW'(RAM - 2), 4, 16'h8000, 1);
        write_out_ofm_en = 1'b0;
        wait_idle(100);
        chk("range_writes", writes_seen - w0, 2);
        chk("range_err_set", range_err, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
